// File: rtl/addsum_ctrl.sv
// Job controller for the accumulate-sum datapath: accepts npass passes of len
// beats, waits out the write pipeline, then reads the accumulator back.
module addsum_ctrl #(
    parameter int C_ASIZE  = 10,
    parameter int C_PSIZE  = 8,
    parameter int C_WR_LAT = 8,
    parameter int C_RD_LAT = 3
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_start,
    input  logic [C_ASIZE:0]   I_len,
    input  logic [C_PSIZE-1:0] I_npass,
    input  logic               I_in_vld,
    output logic               O_in_rdy,
    output logic               O_first_flag,
    output logic               O_dv_pre4,
    output logic               O_dven,
    output logic [C_ASIZE-1:0] O_raddr,
    output logic               O_out_vld,
    output logic               O_out_last,
    output logic               O_busy,
    output logic               O_done
);

    localparam int C_CMAX = (C_WR_LAT > C_RD_LAT) ? C_WR_LAT : C_RD_LAT;
    localparam int C_CW   = $clog2(C_CMAX + 1);
    localparam logic [C_CW-1:0] C_WR_END = C_CW'(C_WR_LAT - 1);
    localparam logic [C_CW-1:0] C_RD_END = C_CW'(C_RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN,
        S_GAP,
        S_READ,
        S_FLUSH
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [C_ASIZE:0]    r_len;
    logic [C_ASIZE:0]    r_beat;
    logic [C_PSIZE-1:0]  r_npass;
    logic [C_PSIZE-1:0]  r_pass;
    logic [C_CW-1:0]     r_cnt;
    logic [C_ASIZE-1:0]  r_raddr;
    logic [C_RD_LAT-1:0] r_vld_dly;
    logic [C_RD_LAT-1:0] r_last_dly;
    logic                r_done;

    logic             w_in_rdy;
    logic             w_accept;
    logic [C_ASIZE:0] w_len_m1;
    logic             w_beat_last;
    logic             w_last_addr;
    logic             w_pass_last;
    logic             w_start_empty;
    logic             w_rd_vld;
    logic             w_dven;

    assign w_in_rdy      = (r_state == S_ACC) && (r_beat < r_len);
    assign w_accept      = w_in_rdy && I_in_vld;
    assign w_len_m1      = r_len - (C_ASIZE+1)'(1);
    assign w_beat_last   = (r_beat == w_len_m1);
    assign w_last_addr   = ({1'b0, r_raddr} == w_len_m1);
    assign w_pass_last   = (r_pass == r_npass - C_PSIZE'(1));
    assign w_start_empty = (I_len == '0) || (I_npass == '0);
    assign w_rd_vld      = (r_state == S_READ);
    assign w_dven        = (r_state == S_ACC) || (r_state == S_DRAIN);

    always_ff @(posedge I_clk) begin
        if (I_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (I_start) w_next = w_start_empty ? S_FLUSH : S_ACC;
            S_ACC:   if (w_accept && w_beat_last) w_next = S_DRAIN;
            S_DRAIN: if (r_cnt == C_WR_END) w_next = w_pass_last ? S_READ : S_GAP;
            S_GAP:   w_next = S_ACC;
            S_READ:  if (w_last_addr) w_next = S_FLUSH;
            S_FLUSH: if (r_cnt == C_RD_END) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The shared cycle counter restarts on every state change, so DRAIN and
    // FLUSH each measure their own length from zero.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_len      <= '0;
            r_npass    <= '0;
            r_pass     <= '0;
            r_beat     <= '0;
            r_cnt      <= '0;
            r_raddr    <= '0;
            r_vld_dly  <= '0;
            r_last_dly <= '0;
            r_done     <= 1'b0;
        end else begin
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state == S_DRAIN || r_state == S_FLUSH)
                r_cnt <= r_cnt + C_CW'(1);

            case (r_state)
                S_IDLE: begin
                    if (I_start) begin
                        r_len   <= I_len;
                        r_npass <= I_npass;
                        r_pass  <= '0;
                        r_beat  <= '0;
                    end
                end
                S_ACC: begin
                    if (w_accept) r_beat <= r_beat + (C_ASIZE+1)'(1);
                end
                S_DRAIN: begin
                    if (r_cnt == C_WR_END && !w_pass_last) begin
                        r_pass <= r_pass + C_PSIZE'(1);
                        r_beat <= '0;
                    end
                end
                S_READ: begin
                    r_raddr <= w_last_addr ? '0 : r_raddr + C_ASIZE'(1);
                end
                default: begin
                end
            endcase

            r_vld_dly[0]  <= w_rd_vld;
            r_last_dly[0] <= w_rd_vld && w_last_addr;
            for (int i = 1; i < C_RD_LAT; i++) begin
                r_vld_dly[i]  <= r_vld_dly[i-1];
                r_last_dly[i] <= r_last_dly[i-1];
            end

            r_done <= (r_state == S_FLUSH) && (w_next == S_IDLE);
        end
    end

    // Outputs are forced low while reset is asserted, not just after the edge.
    assign O_in_rdy     = w_in_rdy && !I_rst;
    assign O_dv_pre4    = w_accept && !I_rst;
    assign O_dven       = w_dven && !I_rst;
    assign O_first_flag = w_dven && (r_pass == '0) && !I_rst;
    assign O_raddr      = I_rst ? '0 : r_raddr;
    assign O_out_vld    = r_vld_dly[C_RD_LAT-1] && !I_rst;
    assign O_out_last   = r_last_dly[C_RD_LAT-1] && !I_rst;
    assign O_busy       = (r_state != S_IDLE) && !I_rst;
    assign O_done       = r_done && !I_rst;

endmodule

// File: tb/tb_addsum_ctrl.sv
// Self-checking bench for addsum_ctrl: directed job table plus random jobs,
// each compared cycle by cycle against a timeline model of the job.
module tb_addsum_ctrl;

    localparam int ASZ  = 2;
    localparam int PSZ  = 8;
    localparam int WR   = 8;
    localparam int RD   = 3;
    localparam int MAXT = 512;

    logic           I_clk = 1'b0;
    logic           I_rst = 1'b1;
    logic           I_start = 1'b0;
    logic [ASZ:0]   I_len = '0;
    logic [PSZ-1:0] I_npass = '0;
    logic           I_in_vld = 1'b0;
    logic           O_in_rdy, O_first_flag, O_dv_pre4, O_dven;
    logic [ASZ-1:0] O_raddr;
    logic           O_out_vld, O_out_last, O_busy, O_done;

    addsum_ctrl #(
        .C_ASIZE (ASZ),
        .C_PSIZE (PSZ),
        .C_WR_LAT(WR),
        .C_RD_LAT(RD)
    ) dut (
        .I_clk       (I_clk),
        .I_rst       (I_rst),
        .I_start     (I_start),
        .I_len       (I_len),
        .I_npass     (I_npass),
        .I_in_vld    (I_in_vld),
        .O_in_rdy    (O_in_rdy),
        .O_first_flag(O_first_flag),
        .O_dv_pre4   (O_dv_pre4),
        .O_dven      (O_dven),
        .O_raddr     (O_raddr),
        .O_out_vld   (O_out_vld),
        .O_out_last  (O_out_last),
        .O_busy      (O_busy),
        .O_done      (O_done)
    );

    always #5 I_clk = ~I_clk;

    typedef struct packed {
        logic           inRdy;
        logic           dv;
        logic           dven;
        logic           first;
        logic [ASZ-1:0] raddr;
        logic           outVld;
        logic           outLast;
        logic           busy;
        logic           done;
    } outVec_t;

    typedef struct {
        int len;
        int npass;
        int mode;
        bit midStart;
        int rstAt;
        int expBeats;
        int expDven;
        int expDone;
    } job_t;

    outVec_t expv[MAXT];
    bit      vldArr[MAXT];
    int      vecCount = 0;
    int      errCount = 0;

    function automatic outVec_t sampleOut();
        return outVec_t'({O_in_rdy, O_dv_pre4, O_dven, O_first_flag, O_raddr,
                          O_out_vld, O_out_last, O_busy, O_done});
    endfunction

    task automatic applyStimulus(input bit rst, input bit start, input int len,
                                 input int npass, input bit vld);
        @(posedge I_clk);
        #1;
        I_rst    = rst;
        I_start  = start;
        I_len    = (ASZ+1)'(len);
        I_npass  = PSZ'(npass);
        I_in_vld = vld;
    endtask

    task automatic checkOutput(input string name, input outVec_t act, input outVec_t want);
        vecCount++;
        if (act !== want) begin
            errCount++;
            $display("[TB] FAIL %s: got %b required %b (rdy dv dven first raddr vld last busy done)",
                     name, act, want);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int want);
        vecCount++;
        if (act != want) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d required %0d", name, act, want);
        end
    endtask

    // Timeline of one job from its start cycle (offset 0), derived from the
    // pass/beat/latency rules rather than from any state machine.
    task automatic buildModel(input int len, input int npass, output int endT);
        int t;
        int beats;
        for (int i = 0; i < MAXT; i++) expv[i] = '0;
        t = 1;
        if (len == 0 || npass == 0) begin
            for (int i = 0; i < RD; i++) begin expv[t].busy = 1'b1; t++; end
        end else begin
            for (int p = 0; p < npass; p++) begin
                beats = 0;
                while (beats < len) begin
                    expv[t].busy  = 1'b1;
                    expv[t].inRdy = 1'b1;
                    expv[t].dven  = 1'b1;
                    expv[t].first = (p == 0);
                    if (vldArr[t]) begin
                        expv[t].dv = 1'b1;
                        beats++;
                    end
                    t++;
                end
                for (int i = 0; i < WR; i++) begin
                    expv[t].busy  = 1'b1;
                    expv[t].dven  = 1'b1;
                    expv[t].first = (p == 0);
                    t++;
                end
                if (p < npass - 1) begin expv[t].busy = 1'b1; t++; end
            end
            for (int a = 0; a < len; a++) begin
                expv[t].busy         = 1'b1;
                expv[t].raddr        = ASZ'(a % (1 << ASZ));
                expv[t+RD].outVld    = 1'b1;
                expv[t+RD].outLast   = (a == len - 1);
                t++;
            end
            for (int i = 0; i < RD; i++) begin expv[t].busy = 1'b1; t++; end
        end
        expv[t].done = 1'b1;
        endT = t;
    endtask

    task automatic runJob(input int id, input int len, input int npass, input int mode,
                          input bit midStart, input int rstAt,
                          output int nDv, output int nDven, output int doneAt);
        int      endT;
        int      lastT;
        outVec_t act;
        outVec_t want;
        for (int t = 0; t < MAXT; t++) begin
            case (mode)
                0:       vldArr[t] = 1'b1;
                1:       vldArr[t] = (t % 2 == 1);
                default: vldArr[t] = ($urandom_range(0, 3) != 0) || (t % 4 == 0);
            endcase
        end
        buildModel(len, npass, endT);
        lastT  = (rstAt >= 0) ? rstAt : endT;
        nDv    = 0;
        nDven  = 0;
        doneAt = -1;
        for (int t = 0; t <= lastT; t++) begin
            applyStimulus(t == rstAt, (t == 0) || (midStart && t == 2),
                          (t == 0) ? len : 1, (t == 0) ? npass : 5, vldArr[t]);
            @(negedge I_clk);
            act  = sampleOut();
            want = (t == rstAt) ? outVec_t'('0) : expv[t];
            checkOutput($sformatf("job%0d cyc%0d", id, t), act, want);
            nDv   += int'(act.dv);
            nDven += int'(act.dven);
            if (act.done && doneAt < 0) doneAt = t;
        end
    endtask

    initial begin
        job_t jobs[9];
        int   nDv, nDven, doneAt;
        int   rl, rn;

        jobs[0] = '{4, 1, 0, 1'b0, -1, 4, 12, 20};
        jobs[1] = '{3, 3, 1, 1'b0, -1, 9, 39, 48};
        jobs[2] = '{4, 1, 0, 1'b1, -1, 4, 12, 20};
        jobs[3] = '{0, 2, 0, 1'b0, -1, 0, 0, 4};
        jobs[4] = '{4, 1, 0, 1'b0, 7, 0, 0, 0};
        jobs[5] = '{2, 1, 0, 1'b0, -1, 2, 10, 16};
        jobs[6] = '{4, 2, 0, 1'b0, -1, 8, 24, 33};
        jobs[7] = '{2, 0, 0, 1'b0, -1, 0, 0, 4};
        jobs[8] = '{1, 1, 0, 1'b0, -1, 1, 9, 14};

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 0, 0, 1'b1);
            @(negedge I_clk);
            checkOutput($sformatf("reset%0d", i), sampleOut(), '0);
        end

        for (int i = 0; i < 9; i++) begin
            runJob(i, jobs[i].len, jobs[i].npass, jobs[i].mode, jobs[i].midStart,
                   jobs[i].rstAt, nDv, nDven, doneAt);
            if (jobs[i].rstAt < 0) begin
                checkInt($sformatf("job%0d beats", i), nDv, jobs[i].expBeats);
                checkInt($sformatf("job%0d dven", i), nDven, jobs[i].expDven);
                checkInt($sformatf("job%0d done", i), doneAt, jobs[i].expDone);
                applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
                @(negedge I_clk);
                checkOutput($sformatf("job%0d idle", i), sampleOut(), '0);
            end
        end

        for (int j = 0; j < 30; j++) begin
            rl = int'($urandom_range(0, 4));
            rn = int'($urandom_range(0, 3));
            runJob(100 + j, rl, rn, 2, ($urandom_range(0, 3) == 0), -1, nDv, nDven, doneAt);
            checkInt($sformatf("rjob%0d beats", j), nDv, (rl == 0) ? 0 : rl * rn);
            applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
            @(negedge I_clk);
            checkOutput($sformatf("rjob%0d idle", j), sampleOut(), '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
